// File: rtl/mult_tile_seq.sv
// ---------------------------------------------------------------------------
// mult_tile_seq
//   Sequential matrix-tile multiplier. ROWS rows of M1 are multiplied by COLS
//   columns of M2 using ROWS*COLS parallel MAC lanes, one vector element per
//   cycle over LEN cycles. Each lane keeps a full-precision accumulator; the
//   final result is reduced to DW bits and a per-tile overflow flag is
//   reported.
//
//   Configuration macro: MULT_TILE_SAT_EN
//     defined   -> overflowing lanes clamp to the signed DW-bit range
//     undefined -> overflowing lanes wrap (low DW bits of the accumulator)
//
// Ports
//   clk    in   1             clock, rising edge
//   rst    in   1             synchronous reset, active-high
//   start  in   1             request a new tile (ignored while busy)
//   lin    in   ROWS*LEN*DW   M1 rows, elem k of row r at [(r*LEN+k)*DW +: DW]
//   col    in   COLS*LEN*DW   M2 cols, elem k of col c at [(c*LEN+k)*DW +: DW]
//   busy   out  1             high while the tile is being computed
//   done   out  1             one-cycle pulse, res/ovf valid
//   res    out  ROWS*COLS*DW  result (r,c) at [(r*COLS+c)*DW +: DW]
//   ovf    out  1             OR of per-lane overflow for the last tile
// ---------------------------------------------------------------------------
module mult_tile_seq #(
  parameter int DW   = 8,
  parameter int LEN  = 4,
  parameter int ROWS = 2,
  parameter int COLS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROWS*LEN*DW-1:0]   lin,
  input  logic [COLS*LEN*DW-1:0]   col,
  output logic                     busy,
  output logic                     done,
  output logic [ROWS*COLS*DW-1:0]  res,
  output logic                     ovf
);

  localparam int NL = ROWS * COLS;
  // Wide enough to hold LEN full products without overflow.
  localparam int AW = 2 * DW + $clog2(LEN) + 1;
  localparam int KW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    state_q;
  logic [KW-1:0]             k_q;
  logic [ROWS*LEN*DW-1:0]    a_q;
  logic [COLS*LEN*DW-1:0]    b_q;
  logic [AW-1:0]             acc_q [NL];
  logic [NL*DW-1:0]          res_q;
  logic                      ovf_q;
  logic                      busy_q;
  logic                      done_q;

  // Element views of the latched operands, and the element selected by k.
  logic [DW-1:0]             a_el  [ROWS][LEN];
  logic [DW-1:0]             b_el  [COLS][LEN];
  logic [DW-1:0]             a_cur [ROWS];
  logic [DW-1:0]             b_cur [COLS];

  // Per-lane next accumulator value and reduced result.
  logic [AW-1:0]             sum_d [NL];
  logic [NL*DW-1:0]          res_d;
  logic [NL-1:0]             lane_ovf_d;
  logic                      ovf_d;

  genvar gi, gj;

  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_a_row
      for (gj = 0; gj < LEN; gj++) begin : g_a_el
        assign a_el[gi][gj] = a_q[(gi*LEN+gj)*DW +: DW];
      end
      assign a_cur[gi] = a_el[gi][k_q];
    end

    for (gi = 0; gi < COLS; gi++) begin : g_b_col
      for (gj = 0; gj < LEN; gj++) begin : g_b_el
        assign b_el[gi][gj] = b_q[(gi*LEN+gj)*DW +: DW];
      end
      assign b_cur[gi] = b_el[gi][k_q];
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_lane_r
      for (gj = 0; gj < COLS; gj++) begin : g_lane_c
        localparam int L = gi * COLS + gj;
        logic [2*DW-1:0] a_ext;
        logic [2*DW-1:0] b_ext;
        logic [2*DW-1:0] prod;
        logic            fits;
        logic [DW-1:0]   lane_res;

        // Sign-extend to 2*DW so the low 2*DW bits of the product are the
        // exact signed product (it always fits in 2*DW signed bits).
        assign a_ext = {{DW{a_cur[gi][DW-1]}}, a_cur[gi]};
        assign b_ext = {{DW{b_cur[gj][DW-1]}}, b_cur[gj]};
        assign prod  = a_ext * b_ext;
        assign sum_d[L] = acc_q[L] + {{(AW-2*DW){prod[2*DW-1]}}, prod};

        // The value fits in DW signed bits iff bits [AW-1:DW-1] are all equal.
        assign fits = (&sum_d[L][AW-1:DW-1]) | ~(|sum_d[L][AW-1:DW-1]);
        assign lane_ovf_d[L] = ~fits;

`ifdef MULT_TILE_SAT_EN
        assign lane_res = fits ? sum_d[L][DW-1:0]
                        : (sum_d[L][AW-1] ? {1'b1, {(DW-1){1'b0}}}
                                          : {1'b0, {(DW-1){1'b1}}});
`else
        assign lane_res = sum_d[L][DW-1:0];
`endif
        assign res_d[L*DW +: DW] = lane_res;
      end
    end
  endgenerate

  assign ovf_d = |lane_ovf_d;

  // Control FSM and datapath registers. res/ovf are only written on the last
  // CALC cycle so partial sums are never visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NL; i++) acc_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          busy_q <= 1'b0;
          if (start) begin
            a_q     <= lin;
            b_q     <= col;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
            for (int i = 0; i < NL; i++) acc_q[i] <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          for (int i = 0; i < NL; i++) acc_q[i] <= sum_d[i];
          if (k_q == K_LAST) begin
            k_q     <= '0;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;
  assign ovf  = ovf_q;

endmodule
